// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length header, 3-byte instruction words and an
// XOR checksum, writes instruction memory, and releases the CPU only after a good load.
module prog_loader #(
  parameter int INSTR_W = 19,
  parameter int ADDR_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst,
  input  logic               cpu_halt,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err_code
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN, HALTED, ERROR
  } state_t;

  // Bits of the first word byte that lie above the instruction width and must be zero.
  localparam logic [7:0]  PAD_MASK = 8'(8'hFF << (INSTR_W - 16));
  localparam logic [16:0] MAX_LEN  = 17'(2 ** ADDR_W);

  state_t      state, next;
  logic [1:0]  err_next;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] wcnt;
  logic [1:0]  bcnt;
  logic [15:0] part;
  logic [7:0]  csum;

  logic        xfer;
  logic        launch;
  logic [16:0] hdr_len;
  logic        bad_len;
  logic        last_word;
  logic [23:0] word;
  logic        loading_next;

  assign xfer         = rx_valid & rx_ready;
  assign launch       = start & (state == IDLE || state == HALTED || state == ERROR);
  assign hdr_len      = {1'b0, len_hi, rx_data};
  assign bad_len      = (hdr_len == 17'd0) || (hdr_len > MAX_LEN);
  assign last_word    = (wcnt + 16'd1) == len;
  assign word         = {part, rx_data};
  assign loading_next = (next == LEN_HI) || (next == LEN_LO) || (next == DATA) || (next == CSUM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next     = state;
    err_next = 2'b00;
    unique case (state)
      IDLE, HALTED, ERROR: if (start) next = LEN_HI;
      LEN_HI: if (xfer) next = LEN_LO;
      LEN_LO: begin
        err_next = 2'b01;
        if (xfer) next = bad_len ? ERROR : DATA;
      end
      DATA: begin
        err_next = 2'b10;
        if (xfer) begin
          if (bcnt == 2'd0 && (rx_data & PAD_MASK) != 8'd0) next = ERROR;
          else if (bcnt == 2'd2 && last_word)               next = CSUM;
        end
      end
      CSUM: begin
        err_next = 2'b11;
        if (xfer) next = (rx_data == csum) ? RUN : ERROR;
      end
      RUN: if (cpu_halt) next = HALTED;
      default: next = IDLE;
    endcase
  end

  // Datapath: header capture, word assembly, checksum and the write strobe/address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi     <= '0;
      len        <= '0;
      wcnt       <= '0;
      bcnt       <= '0;
      part       <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) imem_addr <= imem_addr + 1'b1;
      if (launch) begin
        imem_addr <= '0;
        csum      <= '0;
        bcnt      <= '0;
        wcnt      <= '0;
      end else if (xfer) begin
        unique case (state)
          LEN_HI: len_hi <= rx_data;
          LEN_LO: len    <= {len_hi, rx_data};
          DATA: begin
            csum <= csum ^ rx_data;
            if (bcnt == 2'd0) begin
              part[15:8] <= rx_data;
              bcnt       <= 2'd1;
            end else if (bcnt == 2'd1) begin
              part[7:0] <= rx_data;
              bcnt      <= 2'd2;
            end else begin
              imem_we    <= 1'b1;
              imem_wdata <= word[INSTR_W-1:0];
              bcnt       <= 2'd0;
              wcnt       <= wcnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Status outputs follow the state being entered so they change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      cpu_rst  <= 1'b0;
      done     <= 1'b0;
      err_code <= 2'b00;
    end else begin
      rx_ready <= loading_next;
      busy     <= loading_next;
      cpu_rst  <= (next == RUN) || (next == HALTED);
      done     <= (next == HALTED);
      if (launch)                               err_code <= 2'b00;
      else if (next == ERROR && state != ERROR) err_code <= err_next;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a byte-index reference model checked against the DUT every
// cycle, directed load scenarios with literal expectations, then randomized programs.
module tb_prog_loader;

  localparam int INSTR_W = 19;
  localparam int ADDR_W  = 12;
  localparam int MAXN    = 1 << ADDR_W;
  localparam logic [7:0] PAD = 8'hF8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               rx_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_rst;
  logic               cpu_halt;
  logic               busy;
  logic               done;
  logic [1:0]         err_code;

  prog_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .cpu_halt(cpu_halt), .busy(busy),
    .done(done), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is a position k in the byte stream, not a state machine.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_HALT, M_ERR} mphase_t;
  mphase_t     ph    = M_IDLE;
  int          k     = 0;
  int          nwords = 0;
  int          mpos  = 0;
  int          waddr = 0;
  logic [7:0]  hi    = '0;
  logic [7:0]  cs    = '0;
  logic [23:0] acc   = '0;
  logic [1:0]  merr  = '0;
  logic        mwe   = 1'b0;
  logic        we_now = 1'b0;
  logic [18:0] mdata = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph = M_IDLE; k = 0; cs = '0; merr = '0; mwe = 1'b0; waddr = 0;
    end else begin
      we_now = 1'b0;
      if (mwe) waddr = (waddr + 1) % MAXN;
      case (ph)
        M_IDLE, M_HALT, M_ERR:
          if (start) begin ph = M_LOAD; k = 0; cs = '0; merr = '0; waddr = 0; end
        M_LOAD:
          if (rx_valid) begin
            if (k == 0) hi = rx_data;
            else if (k == 1) begin
              nwords = {hi, rx_data};
              if (nwords == 0 || nwords > MAXN) begin ph = M_ERR; merr = 2'd1; end
            end else if (k < 3 * nwords + 2) begin
              mpos = (k - 2) % 3;
              cs   = cs ^ rx_data;
              acc  = {acc[15:0], rx_data};
              if (mpos == 0 && (rx_data & PAD) != 8'd0) begin ph = M_ERR; merr = 2'd2; end
              if (mpos == 2) begin we_now = 1'b1; mdata = acc[18:0]; end
            end else begin
              if (rx_data == cs) ph = M_RUN;
              else begin ph = M_ERR; merr = 2'd3; end
            end
            k++;
          end
        M_RUN: if (cpu_halt) ph = M_HALT;
        default: ;
      endcase
      mwe = we_now;
    end
  end

  task automatic check_output();
    check("rx_ready", rx_ready, ph == M_LOAD);
    check("busy", busy, ph == M_LOAD);
    check("cpu_rst", cpu_rst, ph == M_RUN || ph == M_HALT);
    check("done", done, ph == M_HALT);
    check("err_code", err_code, merr);
    check("imem_we", imem_we, mwe);
    check("imem_addr", imem_addr, waddr);
    if (mwe) check("imem_wdata", imem_wdata, mdata);
  endtask

  always @(negedge clk) check_output();

  logic [18:0] mem [0:15];
  always @(posedge clk) if (imem_we && imem_addr < 16) mem[imem_addr] <= imem_wdata;

  logic [7:0] stream[$];

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int guard;
    logic ok;
    g = $urandom_range(maxgap, 0);
    repeat (g) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    forever begin
      ok = rx_ready;
      @(posedge clk); #1;
      if (ok) break;
      guard++;
      if (guard > 50) begin check("rx_timeout", 32'd1, 32'd0); break; end
    end
    rx_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input int maxgap);
    foreach (stream[i]) send_byte(stream[i], maxgap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_t1(input logic [7:0] csum_byte);
    stream = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06, 8'h78, 8'h9A, csum_byte};
  endtask

  // Builds a random program; bad==1 corrupts the checksum, bad==2 sets a pad bit.
  task automatic build_random(input int n, input int bad);
    logic [18:0] w;
    logic [7:0]  c;
    logic [7:0]  b0;
    int          badw;
    stream = '{};
    c = '0;
    badw = $urandom_range(n - 1, 0);
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w  = 19'($urandom);
      b0 = {5'd0, w[18:16]};
      if (bad == 2 && i == badw) begin
        stream.push_back(b0 | (8'h08 << $urandom_range(4, 0)));
        return;
      end
      stream.push_back(b0);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
      c = c ^ b0 ^ w[15:8] ^ w[7:0];
    end
    stream.push_back(bad == 1 ? ~c : c);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0; cpu_halt = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_rx_ready", rx_ready, 1'b0);
    check("reset_cpu_rst", cpu_rst, 1'b0);
    check("reset_wdata", imem_wdata, 19'h0);
    check("reset_err", err_code, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: nominal two-word load.
    pulse_start();
    load_t1(8'h83);
    apply_stimulus(0);
    check("t1_cpu_rst", cpu_rst, 1'b1);
    check("t1_err", err_code, 2'b00);
    check("t1_word0", mem[0], 19'h12345);
    check("t1_word1", mem[1], 19'h6789A);
    repeat (2) @(posedge clk); #1;
    cpu_halt = 1'b1; @(posedge clk); #1; cpu_halt = 1'b0;

    // T2: bad checksum.
    pulse_start();
    load_t1(8'h00);
    apply_stimulus(0);
    check("t2_err", err_code, 2'b11);
    check("t2_cpu_rst", cpu_rst, 1'b0);
    check("t2_rx_ready", rx_ready, 1'b0);

    // T3: zero and oversize length.
    pulse_start();
    stream = '{8'h00, 8'h00};
    apply_stimulus(1);
    check("t3_err_zero", err_code, 2'b01);
    pulse_start();
    stream = '{8'h10, 8'h01};
    apply_stimulus(1);
    check("t3_err_big", err_code, 2'b01);

    // T4: pad bit set in the first word byte.
    pulse_start();
    stream = '{8'h00, 8'h01, 8'h08};
    apply_stimulus(0);
    check("t4_err", err_code, 2'b10);

    // T5: gapped T1 stream, halt, then restart from HALTED.
    pulse_start();
    mem[0] = '0; mem[1] = '0;
    load_t1(8'h83);
    apply_stimulus(3);
    check("t5_word0", mem[0], 19'h12345);
    check("t5_word1", mem[1], 19'h6789A);
    repeat (3) @(posedge clk); #1;
    cpu_halt = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("t5_done", done, 1'b1);
    check("t5_cpu_rst_halted", cpu_rst, 1'b1);
    pulse_start();
    cpu_halt = 1'b0;
    check("t5_restart_cpu_rst", cpu_rst, 1'b0);
    check("t5_restart_done", done, 1'b0);
    check("t5_restart_ready", rx_ready, 1'b1);

    // T6: reset mid-DATA, then a fresh full load.
    stream = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45};
    apply_stimulus(0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_rx_ready", rx_ready, 1'b0);
    check("t6_addr", imem_addr, 12'h0);
    check("t6_wdata", imem_wdata, 19'h0);
    rst = 1'b1;
    mem[0] = '0; mem[1] = '0;
    pulse_start();
    load_t1(8'h83);
    apply_stimulus(1);
    check("t6_word0", mem[0], 19'h12345);
    check("t6_word1", mem[1], 19'h6789A);
    check("t6_cpu_rst", cpu_rst, 1'b1);
    cpu_halt = 1'b1; @(posedge clk); #1; cpu_halt = 1'b0;

    // Randomized programs with occasional corruption.
    for (int it = 0; it < 25; it++) begin
      int r;
      r = $urandom_range(9, 0);
      build_random($urandom_range(6, 1), r < 2 ? 1 : (r < 4 ? 2 : 0));
      pulse_start();
      apply_stimulus(2);
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1;
      cpu_halt = 1'b1; @(posedge clk); #1; cpu_halt = 1'b0;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
